// File: rtl/pix_raster_gen_if.sv
// Pixel-stream bus between the raster source and its consumer: valid/ready
// handshake plus the per-pixel coordinate and frame/line markers.
interface pix_raster_gen_if #(
    parameter int XW = 11,
    parameter int YW = 10
) ();
    logic          valid;
    logic          ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;

    modport master (
        input  ready,
        output valid, x, y, sof, eol, eof
    );

    modport slave (
        output ready,
        input  valid, x, y, sof, eol, eof
    );
endinterface

// File: rtl/pix_raster_gen.sv
// Raster pixel-stream source: walks a FRAME_W x FRAME_H frame in raster order
// under valid/ready backpressure, with fixed horizontal/vertical blanking.
module pix_raster_gen #(
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int HBLANK  = 16,
    parameter int VBLANK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_cont,
    pix_raster_gen_if.master  pix,
    output logic              o_hblank,
    output logic              o_vblank,
    output logic              o_busy,
    output logic              o_frame_done
);
    localparam int XW   = $clog2(FRAME_W) + 1;
    localparam int YW   = $clog2(FRAME_H) + 1;
    localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
    localparam logic [BW-1:0] H_INIT = BW'(HBLANK - 1);
    localparam logic [BW-1:0] V_INIT = BW'(VBLANK - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_HBLANK = 2'd2;
    localparam logic [1:0] ST_VBLANK = 2'd3;

    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [BW-1:0] r_cnt;
    logic          r_valid;
    logic          r_sof;
    logic          r_eol;
    logic          r_eof;
    logic          r_hblank;
    logic          r_vblank;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_state;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [BW-1:0] w_cnt;
    logic          w_done;
    logic          w_act;
    logic          w_eol;

    // Next-state logic: x/y always hold the coordinate of the next pixel to present.
    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_cnt   = r_cnt;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state = ST_ACTIVE;
                    w_x     = {XW{1'b0}};
                    w_y     = {YW{1'b0}};
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (pix.ready) begin
                    if (r_x != X_LAST) begin
                        w_x = r_x + XW'(1);
                    end else if (r_y != Y_LAST) begin
                        w_state = ST_HBLANK;
                        w_x     = {XW{1'b0}};
                        w_y     = r_y + YW'(1);
                        w_cnt   = H_INIT;
                    end else begin
                        w_state = ST_VBLANK;
                        w_x     = {XW{1'b0}};
                        w_y     = {YW{1'b0}};
                        w_cnt   = V_INIT;
                    end
                end else begin
                    w_state = ST_ACTIVE;
                end
            end
            ST_HBLANK: begin
                if (r_cnt == {BW{1'b0}}) begin
                    w_state = ST_ACTIVE;
                end else begin
                    w_cnt = r_cnt - BW'(1);
                end
            end
            ST_VBLANK: begin
                if (r_cnt == {BW{1'b0}}) begin
                    w_done  = 1'b1;
                    w_state = i_cont ? ST_ACTIVE : ST_IDLE;
                end else begin
                    w_cnt = r_cnt - BW'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_x     = {XW{1'b0}};
                w_y     = {YW{1'b0}};
                w_cnt   = {BW{1'b0}};
            end
        endcase
    end

    assign w_act = (w_state == ST_ACTIVE);
    assign w_eol = w_act && (w_x == X_LAST);

    // State, coordinates and all outputs registered from the next-state view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_x      <= {XW{1'b0}};
            r_y      <= {YW{1'b0}};
            r_cnt    <= {BW{1'b0}};
            r_valid  <= 1'b0;
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
            r_eof    <= 1'b0;
            r_hblank <= 1'b0;
            r_vblank <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_x      <= w_x;
            r_y      <= w_y;
            r_cnt    <= w_cnt;
            r_valid  <= w_act;
            r_sof    <= w_act && (w_x == {XW{1'b0}}) && (w_y == {YW{1'b0}});
            r_eol    <= w_eol;
            r_eof    <= w_eol && (w_y == Y_LAST);
            r_hblank <= (w_state == ST_HBLANK);
            r_vblank <= (w_state == ST_VBLANK);
            r_busy   <= (w_state != ST_IDLE);
            r_done   <= w_done;
        end
    end

    assign pix.valid    = r_valid;
    assign pix.x        = r_x;
    assign pix.y        = r_y;
    assign pix.sof      = r_sof;
    assign pix.eol      = r_eol;
    assign pix.eof      = r_eof;
    assign o_hblank     = r_hblank;
    assign o_vblank     = r_vblank;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;
endmodule

// File: tb/tb_pix_raster_gen.sv
// Bench for pix_raster_gen: two small-frame instances driven from shared inputs,
// compared per cycle against a frame-walking reference timeline.
module tb_pix_raster_gen;
    localparam int W0 = 4, H0 = 3, HB0 = 2, VB0 = 3;
    localparam int W1 = 5, H1 = 4, HB1 = 1, VB1 = 1;
    localparam int ASZ = 2048;

    typedef struct {
        logic [7:0] f;
        int         x;
        int         y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic ready = 1'b0;

    int checks = 0;
    int errors = 0;

    bit   rd [ASZ];
    bit   ct [ASZ];
    bit   st [ASZ];
    exp_t exp_q[$];

    pix_raster_gen_if #(.XW($clog2(W0) + 1), .YW($clog2(H0) + 1)) if0 ();
    pix_raster_gen_if #(.XW($clog2(W1) + 1), .YW($clog2(H1) + 1)) if1 ();

    logic [1:0] hb_s, vb_s, busy_s, done_s;
    logic [7:0] obs_f [2];
    logic [15:0] obs_x [2];
    logic [15:0] obs_y [2];

    assign if0.ready = ready;
    assign if1.ready = ready;

    pix_raster_gen #(.FRAME_W(W0), .FRAME_H(H0), .HBLANK(HB0), .VBLANK(VB0)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start), .i_cont(cont), .pix(if0),
        .o_hblank(hb_s[0]), .o_vblank(vb_s[0]), .o_busy(busy_s[0]), .o_frame_done(done_s[0])
    );

    pix_raster_gen #(.FRAME_W(W1), .FRAME_H(H1), .HBLANK(HB1), .VBLANK(VB1)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start), .i_cont(cont), .pix(if1),
        .o_hblank(hb_s[1]), .o_vblank(vb_s[1]), .o_busy(busy_s[1]), .o_frame_done(done_s[1])
    );

    assign obs_f[0] = {if0.valid, if0.sof, if0.eol, if0.eof, hb_s[0], vb_s[0], busy_s[0], done_s[0]};
    assign obs_f[1] = {if1.valid, if1.sof, if1.eol, if1.eof, hb_s[1], vb_s[1], busy_s[1], done_s[1]};
    assign obs_x[0] = 16'(if0.x);
    assign obs_y[0] = 16'(if0.y);
    assign obs_x[1] = 16'(if1.x);
    assign obs_y[1] = 16'(if1.y);

    always #5 clk = ~clk;

    function automatic exp_t mk(bit v, int x, int y, bit sof, bit eol, bit eof,
                                bit hb, bit vb, bit busy, bit done);
        exp_t e;
        e.f = {v, sof, eol, eof, hb, vb, busy, done};
        e.x = x;
        e.y = y;
        return e;
    endfunction

    task automatic gen_stim(input int pct_ready, input bit rand_start, input bit rand_cont);
        for (int i = 0; i < ASZ; i++) begin
            rd[i] = ($urandom_range(99) < pct_ready);
            ct[i] = rand_cont ? 1'($urandom_range(1)) : 1'b0;
            st[i] = rand_start ? ($urandom_range(3) == 0) : 1'b0;
        end
    endtask

    // Reference timeline: entry k is the expected output in the k-th cycle after start.
    task automatic build(input int d, input int maxf);
        int  w, h, hb, vb, k, f;
        bit  pend, more;
        w  = (d == 0) ? W0 : W1;
        h  = (d == 0) ? H0 : H1;
        hb = (d == 0) ? HB0 : HB1;
        vb = (d == 0) ? VB0 : VB1;
        k = 0; f = 0; pend = 1'b0; more = 1'b1;
        exp_q.delete();
        while (more) begin
            for (int yy = 0; yy < h; yy++) begin
                for (int xx = 0; xx < w; xx++) begin
                    do begin
                        exp_q.push_back(mk(1'b1, xx, yy, (xx == 0) && (yy == 0), xx == w - 1,
                                           (xx == w - 1) && (yy == h - 1), 1'b0, 1'b0, 1'b1, pend));
                        pend = 1'b0;
                        k++;
                        if (k >= ASZ - 64) rd[k-1] = 1'b1;
                    end while (!rd[k-1]);
                end
                if (yy < h - 1) begin
                    for (int i = 0; i < hb; i++) begin
                        exp_q.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
                        k++;
                    end
                end
            end
            for (int i = 0; i < vb; i++) begin
                exp_q.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
                k++;
            end
            f++;
            ct[k-1] = ct[k-1] && (f < maxf);
            more = ct[k-1];
            pend = 1'b1;
        end
        exp_q.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = k; i < ASZ; i++) st[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int d, input string name);
        do_reset();
        @(negedge clk);
        start = 1'b1; ready = 1'b0; cont = 1'b0;
        @(posedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (obs_f[d] !== exp_q[k].f) begin
                errors++;
                $display("FAIL %s flags dut%0d cycle %0d: got %b expected %b", name, d, k + 1, obs_f[d], exp_q[k].f);
            end
            if (exp_q[k].f[7]) begin
                checks++;
                if (obs_x[d] !== 16'(exp_q[k].x) || obs_y[d] !== 16'(exp_q[k].y)) begin
                    errors++;
                    $display("FAIL %s xy dut%0d cycle %0d: got (%0d,%0d) expected (%0d,%0d)",
                             name, d, k + 1, obs_x[d], obs_y[d], exp_q[k].x, exp_q[k].y);
                end
            end
            start = st[k]; ready = rd[k]; cont = ct[k];
        end
        start = 1'b0; cont = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_f[d] !== 8'h00 || obs_x[d] !== 16'd0 || obs_y[d] !== 16'd0) begin
                errors++;
                $display("FAIL reset dut%0d: got flags %b xy (%0d,%0d) expected all zero", d, obs_f[d], obs_x[d], obs_y[d]);
            end
        end
    endtask

    task automatic test_nominal();
        gen_stim(100, 1'b0, 1'b0);
        build(0, 1);
        run(0, "nominal");
    endtask

    task automatic test_backpressure();
        gen_stim(100, 1'b0, 1'b0);
        rd[1] = 1'b0; rd[2] = 1'b0; rd[3] = 1'b0;
        build(0, 1);
        run(0, "backpressure");
    endtask

    task automatic test_continuous();
        gen_stim(100, 1'b0, 1'b0);
        for (int i = 0; i < ASZ; i++) ct[i] = 1'b1;
        build(0, 2);
        run(0, "continuous");
    endtask

    task automatic test_ignored_inputs();
        gen_stim(50, 1'b1, 1'b1);
        build(0, 1);
        run(0, "ignored");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            gen_stim(int'($urandom_range(90, 30)), 1'b1, 1'b1);
            build(it % 2, int'($urandom_range(3, 1)));
            run(it % 2, "random");
        end
    endtask

    task automatic test_min_blank();
        gen_stim(100, 1'b0, 1'b0);
        for (int i = 0; i < ASZ; i++) ct[i] = 1'b1;
        build(1, 2);
        run(1, "min_blank");
    endtask

    task automatic test_midreset();
        bit found;
        found = 1'b0;
        do_reset();
        @(negedge clk);
        start = 1'b1; ready = 1'b1; cont = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (obs_f[0][7] && obs_x[0] == 16'd2 && obs_y[0] == 16'd1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset reach (2,1): got not reached expected reached within 40 cycles");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_f[0] !== 8'h00 || obs_x[0] !== 16'd0 || obs_y[0] !== 16'd0) begin
            errors++;
            $display("FAIL midreset async: got flags %b xy (%0d,%0d) expected all zero", obs_f[0], obs_x[0], obs_y[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if (obs_f[0] !== 8'h00) begin
                errors++;
                $display("FAIL midreset idle cycle %0d: got flags %b expected 00000000", c, obs_f[0]);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs_f[0] !== 8'b1100_0010 || obs_x[0] !== 16'd0 || obs_y[0] !== 16'd0) begin
            errors++;
            $display("FAIL midreset restart: got flags %b xy (%0d,%0d) expected 11000010 (0,0)", obs_f[0], obs_x[0], obs_y[0]);
        end
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_nominal();
        test_backpressure();
        test_continuous();
        test_ignored_inputs();
        test_min_blank();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pix_raster_gen.md
# pix_raster_gen

Raster pixel-stream source. It is the producing end of the per-pixel enable/coordinate scheme used by the frame pipeline. It walks a FRAME_W x FRAME_H frame in raster order and presents each pixel's X/Y with valid, start-of-frame and end-of-line markers under valid/ready backpressure. It inserts programmable horizontal and vertical blanking and signals frame completion. It drives test-pattern and SGM input stages that otherwise expect a camera-style pixel strobe.

## Interface
- FRAME_W, 640, active pixels per line (>=2)
- FRAME_H, 480, active lines per frame (>=2)
- HBLANK, 16, blanking cycles between lines (>=1)
- VBLANK, 4, blanking cycles after the last line (>=1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one frame when idle
- cont  in  1  continuous mode; sampled on the last VBLANK cycle
- ready  in  1  downstream accepts the current pixel
- valid  out  1  pixel presented
- x  out  $clog2(FRAME_W)+1  pixel column
- y  out  $clog2(FRAME_H)+1  pixel row
- sof  out  1  high with pixel (0,0)
- eol  out  1  high with pixel x==FRAME_W-1
- eof  out  1  high with the last pixel (FRAME_W-1, FRAME_H-1)
- hblank  out  1  in horizontal blanking
- vblank  out  1  in vertical blanking
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after the frame ends

## Operation
- All outputs are registered. On rst, every output is 0, state is IDLE, and the blank counter is 0.
- States:
  - IDLE:
    - start=1 -> ACTIVE with x=0, y=0.
  - ACTIVE:
    - valid=1.
    - A transfer occurs when valid&&ready.
    - Transfer with x<FRAME_W-1: x+1.
    - Transfer with x==FRAME_W-1 and y<FRAME_H-1: enter HBLANK, x=0, y+1.
    - Transfer at (FRAME_W-1, FRAME_H-1): enter VBLANK, x=0, y=0.
  - HBLANK:
    - Lasts exactly HBLANK cycles, independent of ready, then returns to ACTIVE.
  - VBLANK:
    - Lasts exactly VBLANK cycles, independent of ready.
    - On the cycle after VBLANK: frame_done=1.
    - If cont was 1 on the last VBLANK cycle: state is ACTIVE with sof=1.
    - Otherwise: state is IDLE.
- While valid && !ready, x, y, sof, eol and eof hold stable. valid never drops without a transfer.
- sof, eol and eof are combinational functions of the registered x/y, qualified by valid. They are 0 outside ACTIVE.
- hblank=1 only in HBLANK. vblank=1 only in VBLANK.
- start is ignored unless state is IDLE. cont is ignored except on the last VBLANK cycle.
- x and y outside ACTIVE hold the next pixel's coordinate. They are don't-care for consumers.
- rst asserted mid-frame aborts immediately to the reset values. No frame_done is generated.

## Timing
- Latency: start sampled high at edge n -> valid=1, sof=1, x=0, y=0 from cycle n+1.
- Throughput with ready tied high is 1 pixel/cycle in ACTIVE.
- Frame duration with ready=1 is FRAME_W*FRAME_H + (FRAME_H-1)*HBLANK + VBLANK cycles. It starts at the first valid cycle. frame_done is on the following cycle.
- Each ready=0 cycle during ACTIVE extends the frame by one cycle. ready has no effect during blanking.
- In continuous mode there are no idle cycles between frames: the frame_done cycle carries the next frame's sof pixel.
- Counters never wrap past FRAME_W-1 / FRAME_H-1. The widths are as declared, with no modulo beyond the explicit resets.

## Test plan
- Nominal frame, FRAME_W=4, FRAME_H=3, HBLANK=2, VBLANK=3, ready=1, start pulse at cycle 0:
  - 12 valid cycles, in order (0,0)..(3,2).
  - sof at cycle 1.
  - eol at cycles 4, 10 and 16.
  - hblank at cycles 5-6 and 11-12.
  - eof at cycle 16.
  - vblank at cycles 17-19.
  - frame_done at cycle 20, then IDLE with busy=0.
- Backpressure: same setup, ready low for 3 cycles while (1,0) is presented:
  - (1,0) is held stable for 4 cycles.
  - The sequence is otherwise unchanged.
  - frame_done moves to cycle 23.
- Continuous mode with cont=1 throughout: frame_done and sof=1 with x=0, y=0 coincide at cycle 20. The second frame repeats the cycle pattern exactly.
- Ignored and blanking inputs:
  - start pulses during ACTIVE, HBLANK and VBLANK cause no change to the sequence.
  - ready=0 during HBLANK does not lengthen the blanking, which stays at 2 cycles.
- Reset mid-operation: assert rst while at (2,1):
  - All outputs are 0 asynchronously and no frame_done occurs.
  - After release, start produces sof at (0,0) one cycle later.
- Default parameters, ready=1: frame_done occurs exactly 640*480 + 479*16 + 4 cycles after the first valid cycle, and the last pixel is x=639, y=479 with eof=1.
